writeback: RTL and testbench
============================

# writeback

Final stage of the pipelined Y86-64 processor: the M/W pipeline register, the 15-entry register file, and the processor status/halt logic. It captures the memory stage's outputs each cycle and commits `valE`/`valM` to the register file. It serves the decode stage's two combinational register reads and exposes the W-register contents for decode forwarding. It also freezes the machine when a non-AOK status reaches writeback.

## Interface
Parameters:
- `NREGS`, default 15: architectural registers; IDs 0..14; ID 0xF is RNONE.
- `XLEN`, default 64: data width.

Ports:
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `m_stat`  in  4  status from the memory stage; one-hot: bit0 AOK, bit1 HLT, bit2 INS, bit3 ADR.
- `m_icode`  in  4  instruction code from the memory stage.
- `m_valE`, `m_valM`  in  64  ALU result and loaded data.
- `m_dstE`, `m_dstM`  in  4  destination register IDs.
- `W_stall`  in  1  hold the W register. Asserted by pipeline control.
- `d_srcA`, `d_srcB`  in  4  decode read addresses.
- `d_rvalA`, `d_rvalB`  out  64  read data.
- `W_stat`, `W_icode`, `W_dstE`, `W_dstM`  out  4  W register contents, for forwarding and control.
- `W_valE`, `W_valM`  out  64  W register contents.
- `stat`  out  4  architectural processor status.
- `halted`  out  1  sticky freeze flag.
- `retired`  out  64  count of committed instructions.

## Operation
- **W register.** Captures all `m_*` inputs on each edge unless `W_stall` or `halted` is high. When either is high, it holds its value.
- **Register file writes.**
  - Writes happen on the edge at the end of the cycle in which the instruction sits in W.
  - They are enabled only when `W_stat == AOK` and `halted == 0`.
  - Port E writes `W_valE` to `W_dstE`. Port M writes `W_valM` to `W_dstM`.
  - A port whose ID is 0xF does not write.
  - When `W_dstE == W_dstM`, port M wins (popq %rsp semantics).
- **Register file reads.**
  - Purely combinational; an ID of 0xF returns 0.
  - There is no internal write-through. A read in the same cycle as a write to that register returns the old value. Decode covers this by forwarding from `W_valE`/`W_valM`.
- **Status FSM**, states RUN and HALT:
  - RUN → HALT on an edge where `W_stat != AOK`. On that edge `stat <= W_stat` and `halted <= 1`.
  - HALT is absorbing; only reset leaves it.
  - In RUN, `stat` is AOK.
- **Retired counter.**
  - Increments by 1 on an edge where the FSM is in RUN, `W_stat == AOK`, and `W_icode != 1` (nop/bubble).
  - A halt instruction or a faulting instruction does not count.
  - 64-bit, wraps modulo 2^64.
- `m_stat` values that are not one-hot are treated as non-AOK: they halt, and `stat` records the raw value.

## Timing
- Reset (asynchronous, active-low):
  - W register gets stat AOK (0001), icode 1 (nop), dstE/dstM 0xF, valE/valM 0.
  - All registers are 0, `stat` is AOK, `halted` is 0, `retired` is 0.
- Latency:
  - `m_*` to the W outputs: 1 cycle.
  - W outputs to the register file: committed at the next edge, so visible to decode reads 2 edges after capture.
- The edge that moves an instruction out of W is the same edge that commits it. A stalled instruction is committed once per held edge. This is harmless because the writes are idempotent, but `retired` counts it only on the edge where the W register actually loads (`!W_stall`) or the pipeline is free-running. In other words, `retired` increments on the commit edge where `W_stall == 0`.
- The faulting instruction is never written to the register file. Instructions behind it are frozen in M and never reach W.
- `W_stall` and the fault edge together: the FSM still transitions to HALT.

## Structure
- Shared package `y86_pkg`:
  - icode constants: HALT 0, NOP 1, CMOVXX 2, IRMOVQ 3, RMMOVQ 4, MRMOVQ 5, OPQ 6, JXX 7, CALL 8, RET 9, PUSHQ 10, POPQ 11.
  - stat one-hot encodings: STAT_AOK, STAT_HLT, STAT_INS, STAT_ADR.
  - `RNONE = 4'hF` and `RRSP = 4'h4`.
- One sub-module, `regfile`: 15×64 array with 2 asynchronous read ports, 2 write ports with port-M priority, and asynchronous clear. The W register, FSM and counter stay in `writeback`.

## Test plan
- **Reset value and ID 0xF read.** Reset, then read any register → `d_rvalA = 0`. Read ID 0xF → 0. Check `stat = 0001`, `retired = 0`.
- **irmovq commit.** Drive irmovq (icode 3, dstE 2, valE 0x1234) for one cycle.
  - The next edge shows the instruction in W.
  - The following edge makes `d_srcA = 2` read 0x1234.
  - `retired = 1`.
- **Dual write, same register.** popq with dstE = dstM = 4, valE 0x100, valM 0xBEEF → r4 reads 0xBEEF.
- **Fault freeze.** rmmovq with `m_stat = 1000` (ADR) followed by irmovq to r3:
  - `stat = 1000` and `halted = 1`.
  - r3 is unchanged.
  - `retired` is unchanged.
  - W holds the faulting instruction through 10 further cycles.
- **Stall.** Assert `W_stall` for 3 cycles while `m_*` changes → W outputs hold. On release, W captures the current `m_*` value.
- **Reset mid-HALT.** Pull `rst_n` low with `halted = 1` → outputs clear immediately without a clock edge. After release, the FSM is in RUN.

Source files
------------

// File: rtl/writeback_pkg.sv
// Shared Y86-64 definitions: instruction codes, one-hot status encodings,
// special register IDs and the writeback status FSM state type.
package y86_pkg;

   localparam logic [3:0] ICODE_HALT   = 4'h0;
   localparam logic [3:0] ICODE_NOP    = 4'h1;
   localparam logic [3:0] ICODE_CMOVXX = 4'h2;
   localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
   localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
   localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
   localparam logic [3:0] ICODE_OPQ    = 4'h6;
   localparam logic [3:0] ICODE_JXX    = 4'h7;
   localparam logic [3:0] ICODE_CALL   = 4'h8;
   localparam logic [3:0] ICODE_RET    = 4'h9;
   localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
   localparam logic [3:0] ICODE_POPQ   = 4'hB;

   localparam logic [3:0] STAT_AOK = 4'b0001;
   localparam logic [3:0] STAT_HLT = 4'b0010;
   localparam logic [3:0] STAT_INS = 4'b0100;
   localparam logic [3:0] STAT_ADR = 4'b1000;

   localparam logic [3:0] RNONE = 4'hF;
   localparam logic [3:0] RRSP  = 4'h4;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } wb_state_t;

endpackage

// File: rtl/writeback_if.sv
// Memory-stage to writeback bus: everything the M stage hands to the W register.
interface writeback_if #(
   parameter int XLEN = 64
);
   logic [3:0]      m_stat;
   logic [3:0]      m_icode;
   logic [XLEN-1:0] m_valE;
   logic [XLEN-1:0] m_valM;
   logic [3:0]      m_dstE;
   logic [3:0]      m_dstM;

   modport master (output m_stat, m_icode, m_valE, m_valM, m_dstE, m_dstM);
   modport slave  (input  m_stat, m_icode, m_valE, m_valM, m_dstE, m_dstM);
endinterface

// File: rtl/writeback_regfile.sv
// Architectural register file: NREGS x XLEN, two combinational read ports
// (ID 0xF reads 0), two write ports where port M overrides port E on the
// same register, asynchronous clear. No write-through on reads.
module regfile
   import y86_pkg::*;
#(
   parameter int NREGS = 15,
   parameter int XLEN  = 64
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            we,
   input  logic [3:0]      dstE,
   input  logic [XLEN-1:0] valE,
   input  logic [3:0]      dstM,
   input  logic [XLEN-1:0] valM,
   input  logic [3:0]      srcA,
   input  logic [3:0]      srcB,
   output logic [XLEN-1:0] rvalA,
   output logic [XLEN-1:0] rvalB
);

   logic [XLEN-1:0] r_regs [NREGS];
   logic [XLEN-1:0] w_rvalA;
   logic [XLEN-1:0] w_rvalB;

   // Register array update: clear on reset, otherwise port M takes precedence over port E.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
      end else if (we) begin
         for (int i = 0; i < NREGS; i++) begin
            if (dstM != RNONE && dstM == 4'(i))      r_regs[i] <= valM;
            else if (dstE != RNONE && dstE == 4'(i)) r_regs[i] <= valE;
         end
      end
   end

   // Read ports: any ID outside the array (i.e. RNONE) reads as zero.
   always_comb begin
      w_rvalA = '0;
      w_rvalB = '0;
      if (int'(srcA) < NREGS) w_rvalA = r_regs[srcA];
      if (int'(srcB) < NREGS) w_rvalB = r_regs[srcB];
   end

   assign rvalA = w_rvalA;
   assign rvalB = w_rvalB;

endmodule

// File: rtl/writeback.sv
// Y86-64 writeback stage: M/W pipeline register, register file commit,
// status/halt FSM and retired-instruction counter.
module writeback
   import y86_pkg::*;
#(
   parameter int NREGS = 15,
   parameter int XLEN  = 64
) (
   input  logic            clk,
   input  logic            rst_n,
   writeback_if.slave      mem,
   input  logic            W_stall,
   input  logic [3:0]      d_srcA,
   input  logic [3:0]      d_srcB,
   output logic [XLEN-1:0] d_rvalA,
   output logic [XLEN-1:0] d_rvalB,
   output logic [3:0]      W_stat,
   output logic [3:0]      W_icode,
   output logic [3:0]      W_dstE,
   output logic [3:0]      W_dstM,
   output logic [XLEN-1:0] W_valE,
   output logic [XLEN-1:0] W_valM,
   output logic [3:0]      stat,
   output logic            halted,
   output logic [63:0]     retired
);

   logic [3:0]      r_W_stat;
   logic [3:0]      r_W_icode;
   logic [3:0]      r_W_dstE;
   logic [3:0]      r_W_dstM;
   logic [XLEN-1:0] r_W_valE;
   logic [XLEN-1:0] r_W_valM;
   wb_state_t       r_state;
   wb_state_t       w_state_nxt;
   logic [3:0]      r_stat;
   logic [3:0]      w_stat_nxt;
   logic [63:0]     r_retired;
   logic            w_run;
   logic            w_w_ok;
   logic            w_commit;
   logic            w_load;
   logic            w_retire;

   assign w_run    = (r_state == ST_RUN);
   assign w_w_ok   = (r_W_stat == STAT_AOK);
   assign w_commit = w_run && w_w_ok;
   // A faulting instruction in W blocks the load so it stays visible and
   // everything behind it remains frozen in M.
   assign w_load   = w_commit && !W_stall;
   assign w_retire = w_commit && !W_stall && (r_W_icode != ICODE_NOP);

   // M/W pipeline register: load from the memory stage unless stalled or frozen.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_W_stat  <= STAT_AOK;
         r_W_icode <= ICODE_NOP;
         r_W_dstE  <= RNONE;
         r_W_dstM  <= RNONE;
         r_W_valE  <= '0;
         r_W_valM  <= '0;
      end else if (w_load) begin
         r_W_stat  <= mem.m_stat;
         r_W_icode <= mem.m_icode;
         r_W_dstE  <= mem.m_dstE;
         r_W_dstM  <= mem.m_dstM;
         r_W_valE  <= mem.m_valE;
         r_W_valM  <= mem.m_valM;
      end
   end

   // Status FSM state and recorded status.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_RUN;
         r_stat  <= STAT_AOK;
      end else begin
         r_state <= w_state_nxt;
         r_stat  <= w_stat_nxt;
      end
   end

   // Next state: any non-AOK status (including non-one-hot) reaching W halts for good.
   always_comb begin
      w_state_nxt = r_state;
      w_stat_nxt  = r_stat;
      case (r_state)
         ST_RUN: begin
            if (!w_w_ok) begin
               w_state_nxt = ST_HALT;
               w_stat_nxt  = r_W_stat;
            end
         end
         ST_HALT: begin
            w_state_nxt = ST_HALT;
         end
         default: begin
            w_state_nxt = ST_HALT;
         end
      endcase
   end

   // Retired counter: counts real instructions leaving W on a non-stalled edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_retired <= '0;
      else if (w_retire) r_retired <= r_retired + 64'd1;
   end

   regfile #(
      .NREGS (NREGS),
      .XLEN  (XLEN)
   ) u_regfile (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (w_commit),
      .dstE  (r_W_dstE),
      .valE  (r_W_valE),
      .dstM  (r_W_dstM),
      .valM  (r_W_valM),
      .srcA  (d_srcA),
      .srcB  (d_srcB),
      .rvalA (d_rvalA),
      .rvalB (d_rvalB)
   );

   assign W_stat  = r_W_stat;
   assign W_icode = r_W_icode;
   assign W_dstE  = r_W_dstE;
   assign W_dstM  = r_W_dstM;
   assign W_valE  = r_W_valE;
   assign W_valM  = r_W_valM;
   assign stat    = r_stat;
   assign halted  = !w_run;
   assign retired = r_retired;

endmodule

// File: tb/tb_writeback.sv
// Self-checking bench for the writeback stage: directed vector table,
// hand-written fault/reset sequences and randomized traffic against a model.
module tb_writeback;
   import y86_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        W_stall;
   logic [3:0]  d_srcA, d_srcB;
   logic [63:0] d_rvalA, d_rvalB;
   logic [3:0]  W_stat, W_icode, W_dstE, W_dstM;
   logic [63:0] W_valE, W_valM;
   logic [3:0]  stat;
   logic        halted;
   logic [63:0] retired;

   always #5 clk = ~clk;

   writeback_if #(.XLEN(64)) u_if ();

   writeback #(.NREGS(15), .XLEN(64)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .mem     (u_if.slave),
      .W_stall (W_stall),
      .d_srcA  (d_srcA),
      .d_srcB  (d_srcB),
      .d_rvalA (d_rvalA),
      .d_rvalB (d_rvalB),
      .W_stat  (W_stat),
      .W_icode (W_icode),
      .W_dstE  (W_dstE),
      .W_dstM  (W_dstM),
      .W_valE  (W_valE),
      .W_valM  (W_valM),
      .stat    (stat),
      .halted  (halted),
      .retired (retired)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [3:0]  stat;
      logic [3:0]  icode;
      logic [63:0] valE;
      logic [63:0] valM;
      logic [3:0]  dstE;
      logic [3:0]  dstM;
   } inst_t;

   function automatic inst_t mk(input logic [3:0] s, input logic [3:0] ic,
                                input logic [63:0] vE, input logic [63:0] vM,
                                input logic [3:0] dE, input logic [3:0] dM);
      inst_t x;
      x.stat = s; x.icode = ic; x.valE = vE; x.valM = vM; x.dstE = dE; x.dstM = dM;
      return x;
   endfunction

   task automatic drive(input inst_t x, input logic stall, input logic [3:0] a, input logic [3:0] b);
      u_if.m_stat  = x.stat;
      u_if.m_icode = x.icode;
      u_if.m_valE  = x.valE;
      u_if.m_valM  = x.valM;
      u_if.m_dstE  = x.dstE;
      u_if.m_dstM  = x.dstM;
      W_stall      = stall;
      d_srcA       = a;
      d_srcB       = b;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- reference model ----------------
   logic [63:0] m_regs [16];
   inst_t       m_W;
   bit          m_halt;
   logic [3:0]  m_stat;
   logic [63:0] m_ret;

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_regs[i] = 64'd0;
      m_W    = mk(STAT_AOK, ICODE_NOP, 64'd0, 64'd0, RNONE, RNONE);
      m_halt = 1'b0;
      m_stat = STAT_AOK;
      m_ret  = 64'd0;
   endtask

   // One clock edge: the instruction in W commits/retires/faults, then W
   // takes the new instruction if the machine is still flowing.
   task automatic model_edge(input inst_t x, input bit stall);
      inst_t old = m_W;
      bit    ok  = !m_halt && (old.stat == STAT_AOK);
      if (ok) begin
         if (old.dstE != RNONE) m_regs[old.dstE] = old.valE;
         if (old.dstM != RNONE) m_regs[old.dstM] = old.valM;
         if (old.icode != ICODE_NOP && !stall) m_ret = m_ret + 64'd1;
         if (!stall) m_W = x;
      end else if (!m_halt) begin
         m_halt = 1'b1;
         m_stat = old.stat;
      end
   endtask

   task automatic check_model(input string tag);
      chk({tag, ".W_stat"},  {60'd0, W_stat},  {60'd0, m_W.stat});
      chk({tag, ".W_icode"}, {60'd0, W_icode}, {60'd0, m_W.icode});
      chk({tag, ".W_dstE"},  {60'd0, W_dstE},  {60'd0, m_W.dstE});
      chk({tag, ".W_dstM"},  {60'd0, W_dstM},  {60'd0, m_W.dstM});
      chk({tag, ".W_valE"},  W_valE,           m_W.valE);
      chk({tag, ".W_valM"},  W_valM,           m_W.valM);
      chk({tag, ".stat"},    {60'd0, stat},    {60'd0, m_stat});
      chk({tag, ".halted"},  {63'd0, halted},  {63'd0, m_halt});
      chk({tag, ".retired"}, retired,          m_ret);
      chk({tag, ".rvalA"},   d_rvalA,          (d_srcA == RNONE) ? 64'd0 : m_regs[d_srcA]);
      chk({tag, ".rvalB"},   d_rvalB,          (d_srcB == RNONE) ? 64'd0 : m_regs[d_srcB]);
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      inst_t       in;
      logic        stall;
      logic [3:0]  srcA;
      logic [63:0] e_rvalA;
      logic [63:0] e_WvalE;
      logic [63:0] e_ret;
   } vec_t;

   vec_t  tbl [11];
   inst_t nop_i;
   inst_t x;

   initial begin
      nop_i = mk(STAT_AOK, ICODE_NOP, 64'd0, 64'd0, RNONE, RNONE);
      tbl[0]  = '{mk(STAT_AOK, ICODE_IRMOVQ, 64'h1234, 64'd0, 4'd2, RNONE), 1'b0, 4'd2, 64'd0,      64'h1234, 64'd0};
      tbl[1]  = '{nop_i,                                                   1'b0, 4'd2, 64'h1234,   64'd0,    64'd1};
      tbl[2]  = '{mk(STAT_AOK, ICODE_POPQ, 64'h100, 64'hBEEF, RRSP, RRSP), 1'b0, 4'd4, 64'd0,      64'h100,  64'd1};
      tbl[3]  = '{nop_i,                                                   1'b0, 4'd4, 64'hBEEF,   64'd0,    64'd2};
      tbl[4]  = '{nop_i,                                                   1'b0, RNONE, 64'd0,     64'd0,    64'd2};
      tbl[5]  = '{mk(STAT_AOK, ICODE_IRMOVQ, 64'h55, 64'd0, 4'd5, RNONE),  1'b0, 4'd5, 64'd0,      64'h55,   64'd2};
      tbl[6]  = '{mk(STAT_AOK, ICODE_IRMOVQ, 64'h66, 64'd0, 4'd6, RNONE),  1'b1, 4'd5, 64'h55,     64'h55,   64'd2};
      tbl[7]  = '{mk(STAT_AOK, ICODE_IRMOVQ, 64'h77, 64'd0, 4'd7, RNONE),  1'b1, 4'd7, 64'd0,      64'h55,   64'd2};
      tbl[8]  = '{nop_i,                                                   1'b1, 4'd5, 64'h55,     64'h55,   64'd2};
      tbl[9]  = '{mk(STAT_AOK, ICODE_IRMOVQ, 64'h66, 64'd0, 4'd6, RNONE),  1'b0, 4'd6, 64'd0,      64'h66,   64'd3};
      tbl[10] = '{nop_i,                                                   1'b0, 4'd6, 64'h66,     64'd0,    64'd4};

      // Reset state and ID 0xF read
      rst_n = 1'b0;
      drive(nop_i, 1'b0, 4'd0, RNONE);
      #12;
      chk("rst.rvalA_r0",  d_rvalA, 64'd0);
      chk("rst.rvalB_rF",  d_rvalB, 64'd0);
      chk("rst.stat",      {60'd0, stat}, {60'd0, STAT_AOK});
      chk("rst.halted",    {63'd0, halted}, 64'd0);
      chk("rst.retired",   retired, 64'd0);
      chk("rst.W_icode",   {60'd0, W_icode}, {60'd0, ICODE_NOP});
      chk("rst.W_dstE",    {60'd0, W_dstE}, {60'd0, RNONE});
      rst_n = 1'b1;

      for (int i = 0; i < 11; i++) begin
         drive(tbl[i].in, tbl[i].stall, tbl[i].srcA, RNONE);
         tick();
         chk($sformatf("vec%0d.rvalA", i),   d_rvalA, tbl[i].e_rvalA);
         chk($sformatf("vec%0d.W_valE", i),  W_valE,  tbl[i].e_WvalE);
         chk($sformatf("vec%0d.retired", i), retired, tbl[i].e_ret);
         chk($sformatf("vec%0d.halted", i),  {63'd0, halted}, 64'd0);
      end

      // Fault freeze: ADR rmmovq followed by irmovq to r3
      drive(mk(STAT_ADR, ICODE_RMMOVQ, 64'hAAA, 64'd0, RNONE, RNONE), 1'b0, 4'd3, RNONE);
      tick();
      chk("fault.W_stat_in_W", {60'd0, W_stat}, {60'd0, STAT_ADR});
      chk("fault.not_yet_halted", {63'd0, halted}, 64'd0);
      drive(mk(STAT_AOK, ICODE_IRMOVQ, 64'h333, 64'd0, 4'd3, RNONE), 1'b0, 4'd3, RNONE);
      tick();
      chk("fault.stat",    {60'd0, stat}, {60'd0, STAT_ADR});
      chk("fault.halted",  {63'd0, halted}, 64'd1);
      for (int i = 0; i < 10; i++) begin
         x = mk(STAT_AOK, ICODE_IRMOVQ, {$urandom, $urandom}, 64'd0, 4'd3, RNONE);
         drive(x, 1'($urandom_range(0, 1)), 4'd3, RNONE);
         tick();
         chk($sformatf("freeze%0d.W_icode", i), {60'd0, W_icode}, {60'd0, ICODE_RMMOVQ});
         chk($sformatf("freeze%0d.W_valE", i),  W_valE, 64'hAAA);
         chk($sformatf("freeze%0d.r3", i),      d_rvalA, 64'd0);
         chk($sformatf("freeze%0d.retired", i), retired, 64'd4);
         chk($sformatf("freeze%0d.stat", i),    {60'd0, stat}, {60'd0, STAT_ADR});
      end

      // Reset mid-HALT: clears without a clock edge
      drive(nop_i, 1'b0, 4'd2, RNONE);
      #1;
      rst_n = 1'b0;
      #1;
      chk("rsthalt.halted",  {63'd0, halted}, 64'd0);
      chk("rsthalt.stat",    {60'd0, stat}, {60'd0, STAT_AOK});
      chk("rsthalt.retired", retired, 64'd0);
      chk("rsthalt.W_stat",  {60'd0, W_stat}, {60'd0, STAT_AOK});
      chk("rsthalt.r2",      d_rvalA, 64'd0);
      rst_n = 1'b1;
      drive(mk(STAT_AOK, ICODE_IRMOVQ, 64'hABC, 64'd0, 4'd2, RNONE), 1'b0, 4'd2, RNONE);
      tick();
      drive(nop_i, 1'b0, 4'd2, RNONE);
      tick();
      chk("after_rst.r2",      d_rvalA, 64'hABC);
      chk("after_rst.retired", retired, 64'd1);
      chk("after_rst.halted",  {63'd0, halted}, 64'd0);

      // Randomized traffic against the reference model
      rst_n = 1'b0;
      #1;
      model_reset();
      check_model("rnd_rst");
      rst_n = 1'b1;
      begin
         int halt_cycles;
         halt_cycles = 0;
         for (int c = 0; c < 600; c++) begin
            logic [3:0] s;
            logic       st;
            s  = ($urandom_range(0, 24) == 0) ? 4'($urandom_range(0, 15)) : STAT_AOK;
            st = ($urandom_range(0, 3) == 0);
            x  = mk(s, 4'($urandom_range(0, 11)), {$urandom, $urandom}, {$urandom, $urandom},
                    4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            drive(x, st, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            tick();
            model_edge(x, st);
            check_model($sformatf("rnd%0d", c));
            if (m_halt) halt_cycles++;
            if (halt_cycles > 4) begin
               rst_n = 1'b0;
               #1;
               model_reset();
               check_model($sformatf("rnd%0d_rst", c));
               rst_n = 1'b1;
               halt_cycles = 0;
            end
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
